// File: rtl/rm_sched_pkg.sv
// Shared types and widths for the runtime-monitor cluster scheduler.
package rm_sched_pkg;

    localparam int SYM_W = 8;
    localparam int IDX_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALT,
        ST_FLUSH
    } sched_state_t;

endpackage

// File: rtl/rm_sym_fifo.sv
// Symbol FIFO between the source arbiter and the cluster issue stage.
module rm_sym_fifo
    import rm_sched_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [SYM_W-1:0] i_data,
    input  logic             i_pop,
    output logic [SYM_W-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SYM_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_cnt;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_data  = r_mem[r_rd];
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/rm_cluster_sched.sv
// Arbitrates symbol sources into a FIFO, issues symbols to the monitor
// cluster, aligns returned flags with issue tags and sequences flushes.
module rm_cluster_sched
    import rm_sched_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int NUM_LTL    = 5,
    parameter int DEPTH      = 8,
    parameter int FLAG_LAT   = 1,
    parameter int RST_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_SRC-1:0]       src_valid,
    input  logic [NUM_SRC*SYM_W-1:0] src_symbol,
    output logic [NUM_SRC-1:0]       src_ready,
    input  logic                     enable,
    input  logic                     clear,
    input  logic                     halt_on_viol,
    output logic                     mon_run,
    output logic [SYM_W-1:0]         mon_symbols,
    output logic                     mon_reset,
    input  logic [NUM_LTL-1:0]       mon_flags,
    output logic [NUM_LTL-1:0]       viol_sticky,
    output logic                     viol_irq,
    output logic [IDX_W-1:0]         first_viol_idx,
    output logic [IDX_W-1:0]         sym_count,
    output logic                     busy
);

    localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    sched_state_t     r_state;
    logic [PW-1:0]    r_rr;
    logic [CW-1:0]    r_rst_cnt;
    logic             r_mon_run;
    logic [SYM_W-1:0] r_mon_sym;
    logic             r_mon_reset;
    logic [NUM_LTL-1:0] r_sticky;
    logic [IDX_W-1:0] r_first;
    logic [IDX_W-1:0] r_count;
    logic [IDX_W-1:0] r_cur_idx;
    logic [FLAG_LAT-1:0] r_tag_v;
    logic [IDX_W-1:0] r_tag_idx [FLAG_LAT];

    logic [NUM_SRC-1:0] w_grant;
    logic [PW-1:0]    w_gidx;
    logic             w_any;
    logic [PW:0]      w_sum;
    logic [PW-1:0]    w_idx;
    logic [SYM_W-1:0] w_din;
    logic [SYM_W-1:0] w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_tag_v;
    logic [NUM_LTL-1:0] w_flags;
    logic             w_viol;
    logic             w_flush;
    logic             w_issue;

    // Round-robin search starting at r_rr; first valid source wins.
    always_comb begin
        w_grant = '0;
        w_gidx  = '0;
        w_any   = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        w_din   = '0;
        if (r_state != ST_FLUSH && !w_full) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                w_sum = {1'b0, r_rr} + (PW+1)'(k);
                if (w_sum >= (PW+1)'(NUM_SRC)) begin
                    w_sum = w_sum - (PW+1)'(NUM_SRC);
                end
                w_idx = w_sum[PW-1:0];
                if (!w_any && src_valid[w_idx]) begin
                    w_any          = 1'b1;
                    w_grant[w_idx] = 1'b1;
                    w_gidx         = w_idx;
                end
            end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_grant[i]) begin
                w_din = src_symbol[i*SYM_W +: SYM_W];
            end
        end
    end

    assign w_tag_v = r_tag_v[FLAG_LAT-1];
    assign w_flags = w_tag_v ? mon_flags : '0;
    assign w_viol  = |w_flags;
    assign w_flush = clear || (r_state == ST_FLUSH);
    assign w_issue = (r_state == ST_RUN) && !w_empty && !clear
                     && !(halt_on_viol && w_viol);

    rm_sym_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .i_flush(w_flush),
        .i_push (w_any),
        .i_data (w_din),
        .i_pop  (w_issue),
        .o_data (w_head),
        .o_full (w_full),
        .o_empty(w_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_mon_reset <= 1'b0;
            r_rst_cnt   <= '0;
        end else if (clear) begin
            r_state     <= ST_FLUSH;
            r_mon_reset <= 1'b1;
            r_rst_cnt   <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (enable) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (halt_on_viol && w_viol) r_state <= ST_HALT;
                    else if (!enable)           r_state <= ST_IDLE;
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                ST_FLUSH: begin
                    if (r_rst_cnt == CW'(RST_CYCLES - 1)) begin
                        r_state     <= ST_IDLE;
                        r_mon_reset <= 1'b0;
                        r_rst_cnt   <= '0;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mon_run <= 1'b0;
            r_mon_sym <= '0;
            r_cur_idx <= '0;
            r_count   <= '0;
            r_rr      <= '0;
            r_sticky  <= '0;
            r_first   <= '0;
        end else begin
            r_mon_run <= w_issue;
            if (w_issue) begin
                r_mon_sym <= w_head;
                r_cur_idx <= r_count;
            end
            if (w_flush) begin
                r_count  <= '0;
                r_rr     <= '0;
                r_sticky <= '0;
                r_first  <= '0;
            end else begin
                if (w_issue) r_count <= r_count + 1'b1;
                if (w_any) begin
                    r_rr <= (w_gidx == PW'(NUM_SRC - 1)) ? '0 : w_gidx + 1'b1;
                end
                if (w_viol) begin
                    if (r_sticky == '0) r_first <= r_tag_idx[FLAG_LAT-1];
                    r_sticky <= r_sticky | w_flags;
                end
            end
        end
    end

    // Tag i is valid in the cycle the cluster answers for that symbol.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tag_v <= '0;
            for (int i = 0; i < FLAG_LAT; i++) r_tag_idx[i] <= '0;
        end else if (w_flush) begin
            r_tag_v <= '0;
        end else begin
            r_tag_v[0]   <= r_mon_run;
            r_tag_idx[0] <= r_cur_idx;
            for (int i = 1; i < FLAG_LAT; i++) begin
                r_tag_v[i]   <= r_tag_v[i-1];
                r_tag_idx[i] <= r_tag_idx[i-1];
            end
        end
    end

    assign src_ready      = w_grant;
    assign mon_run        = r_mon_run;
    assign mon_symbols    = r_mon_sym;
    assign mon_reset      = r_mon_reset;
    assign viol_sticky    = r_sticky;
    assign viol_irq       = |r_sticky;
    assign first_viol_idx = r_first;
    assign sym_count      = r_count;
    assign busy           = !w_empty || r_mon_run || (|r_tag_v)
                            || (r_state == ST_FLUSH);

endmodule
